immu_itlb: RTL and testbench

//  Parametrised instruction-side TLB with a registered lookup pipeline and a miss/refill handshake.

---
 rtl/immu_itlb.sv | 273 +++++++++++++++++++++++++++
 tb/tb_immu_itlb.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/immu_itlb.sv
// immu_itlb: fully-associative instruction TLB with a registered lookup stage
// and a miss/refill handshake toward an external page-table walker.
// A lookup is accepted in IDLE and resolved in LOOKUP: a single match returns
// {RPN, offset} or an execute-permission fault, several matches return a
// multi-hit fault, and no match raises a refill request. A fill replays the
// lookup; a fill error returns an ITLB-miss fault.
// Optional build macro IMMU_PERF_CNT_EN adds saturating hit/miss counters;
// without it hit_cnt_o/miss_cnt_o are tied to zero and no counter flops exist.
module immu_itlb #(
  parameter int ENTRIES   = 8,
  parameter int EA_W      = 32,
  parameter int PAGE_BITS = 12,
  parameter int PID_W     = 8,
  parameter int RPN_W     = 20
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [EA_W-1:0]            req_ea_i,
  input  logic [PID_W-1:0]           pid0_i,
  input  logic [PID_W-1:0]           pid1_i,
  input  logic [PID_W-1:0]           pid2_i,
  input  logic                       msr_is_i,
  input  logic                       msr_pr_i,
  output logic                       rsp_valid_o,
  output logic [RPN_W+PAGE_BITS-1:0] rsp_pa_o,
  output logic [4:0]                 rsp_exc_o,
  output logic                       miss_valid_o,
  input  logic                       miss_ready_i,
  output logic [EA_W-PAGE_BITS-1:0]  miss_epn_o,
  input  logic                       fill_valid_i,
  input  logic                       fill_err_i,
  input  logic                       fill_ts_i,
  input  logic [PID_W-1:0]           fill_tid_i,
  input  logic [EA_W-PAGE_BITS-1:0]  fill_epn_i,
  input  logic [RPN_W-1:0]           fill_rpn_i,
  input  logic [5:0]                 fill_permis_i,
  input  logic                       inv_all_i,
  output logic [31:0]                hit_cnt_o,
  output logic [31:0]                miss_cnt_o
);

  localparam int EPN_W = EA_W - PAGE_BITS;
  localparam int PA_W  = RPN_W + PAGE_BITS;
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [1:0] S_IDLE      = 2'd0;
  localparam logic [1:0] S_LOOKUP    = 2'd1;
  localparam logic [1:0] S_MISS_REQ  = 2'd2;
  localparam logic [1:0] S_MISS_WAIT = 2'd3;

  localparam logic [4:0] EXC_NONE  = 5'b00000;
  localparam logic [4:0] EXC_MISS  = 5'b00001;
  localparam logic [4:0] EXC_ISI   = 5'b00010;
  localparam logic [4:0] EXC_MULTI = 5'b00100;

  logic [1:0]       state_q, state_d;
  logic [EA_W-1:0]  ea_q, ea_d;
  logic [PID_W-1:0] pid0_q, pid0_d, pid1_q, pid1_d, pid2_q, pid2_d;
  logic             is_q, is_d, pr_q, pr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [PA_W-1:0]  rsp_pa_q, rsp_pa_d;
  logic [4:0]       rsp_exc_q, rsp_exc_d;
  logic [IDX_W-1:0] victim_q, victim_d;
  logic [ENTRIES-1:0] v_q, v_d;

  // Entry payload; only UX/SX of the permission field matter for fetch.
  logic             ts_q  [ENTRIES];
  logic [PID_W-1:0] tid_q [ENTRIES];
  logic [EPN_W-1:0] epn_q [ENTRIES];
  logic [RPN_W-1:0] rpn_q [ENTRIES];
  logic [1:0]       x_q   [ENTRIES];

  logic [ENTRIES-1:0] match;
  logic [CNT_W-1:0]   match_cnt;
  logic [RPN_W-1:0]   hit_rpn;
  logic [1:0]         hit_x;
  logic               perm_ok;
  logic [ENTRIES-1:0] v_base;
  logic [IDX_W-1:0]   fill_idx;
  logic               free_found;
  logic               fill_we;
  logic               hit_evt, miss_evt;

  logic unused_permis;
  assign unused_permis = ^fill_permis_i[3:0];

  // Match the registered request against every entry and merge the hit payload.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so no latch is inferred.
    match     = '0;
    match_cnt = '0;
    hit_rpn   = '0;
    hit_x     = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      match[i] = v_q[i] && (ts_q[i] == is_q) && (epn_q[i] == ea_q[EA_W-1:PAGE_BITS]) &&
                 ((tid_q[i] == '0) || (tid_q[i] == pid0_q) ||
                  (tid_q[i] == pid1_q) || (tid_q[i] == pid2_q));
      match_cnt = match_cnt + CNT_W'(match[i]);
      if (match[i]) begin
        hit_rpn = hit_rpn | rpn_q[i];
        hit_x   = hit_x | x_q[i];
      end
    end
  end

  // x_q holds {UX, SX}; user mode needs UX, supervisor needs SX.
  assign perm_ok = pr_q ? hit_x[1] : hit_x[0];

  // Choose the fill slot: lowest invalid entry (after a same-cycle inv_all), else the victim pointer.
  always_comb begin
    v_base     = inv_all_i ? '0 : v_q;
    fill_idx   = victim_q;
    free_found = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (!free_found && !v_base[i]) begin
        fill_idx   = IDX_W'(i);
        free_found = 1'b1;
      end
    end
    fill_we  = fill_valid_i && !fill_err_i;
    v_d      = v_base;
    victim_d = victim_q;
    if (fill_we) begin
      v_d[fill_idx] = 1'b1;
      if (!free_found) victim_d = victim_q + IDX_W'(1);
    end
  end

  // Lookup FSM: request capture, match resolution, refill handshake and response generation.
  always_comb begin
    state_d     = state_q;
    ea_d        = ea_q;
    pid0_d      = pid0_q;
    pid1_d      = pid1_q;
    pid2_d      = pid2_q;
    is_d        = is_q;
    pr_d        = pr_q;
    rsp_valid_d = 1'b0;
    rsp_pa_d    = rsp_pa_q;
    rsp_exc_d   = rsp_exc_q;
    hit_evt     = 1'b0;
    miss_evt    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          ea_d    = req_ea_i;
          pid0_d  = pid0_i;
          pid1_d  = pid1_i;
          pid2_d  = pid2_i;
          is_d    = msr_is_i;
          pr_d    = msr_pr_i;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (match_cnt > CNT_W'(1)) begin
          rsp_valid_d = 1'b1;
          rsp_pa_d    = '0;
          rsp_exc_d   = EXC_MULTI;
          state_d     = S_IDLE;
        end else if (match_cnt == CNT_W'(1)) begin
          rsp_valid_d = 1'b1;
          if (perm_ok) begin
            rsp_pa_d  = {hit_rpn, ea_q[PAGE_BITS-1:0]};
            rsp_exc_d = EXC_NONE;
            hit_evt   = 1'b1;
          end else begin
            rsp_pa_d  = '0;
            rsp_exc_d = EXC_ISI;
          end
          state_d = S_IDLE;
        end else begin
          miss_evt = 1'b1;
          state_d  = S_MISS_REQ;
        end
      end
      S_MISS_REQ: begin
        if (miss_ready_i) state_d = S_MISS_WAIT;
      end
      S_MISS_WAIT: begin
        if (fill_valid_i) begin
          if (fill_err_i) begin
            rsp_valid_d = 1'b1;
            rsp_pa_d    = '0;
            rsp_exc_d   = EXC_MISS;
            state_d     = S_IDLE;
          end else begin
            state_d = S_LOOKUP;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and valid bits; reset drops any in-flight lookup.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      state_q     <= S_IDLE;
      ea_q        <= '0;
      pid0_q      <= '0;
      pid1_q      <= '0;
      pid2_q      <= '0;
      is_q        <= 1'b0;
      pr_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_pa_q    <= '0;
      rsp_exc_q   <= '0;
      victim_q    <= '0;
      v_q         <= '0;
    end else begin
      state_q     <= state_d;
      ea_q        <= ea_d;
      pid0_q      <= pid0_d;
      pid1_q      <= pid1_d;
      pid2_q      <= pid2_d;
      is_q        <= is_d;
      pr_q        <= pr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pa_q    <= rsp_pa_d;
      rsp_exc_q   <= rsp_exc_d;
      victim_q    <= victim_d;
      v_q         <= v_d;
    end
  end

  // Entry payload write on an accepted fill.
  // NOTE: the payload array has no reset; the V bits alone decide whether an entry can match.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      ts_q[fill_idx]  <= fill_ts_i;
      tid_q[fill_idx] <= fill_tid_i;
      epn_q[fill_idx] <= fill_epn_i;
      rpn_q[fill_idx] <= fill_rpn_i;
      x_q[fill_idx]   <= fill_permis_i[5:4];
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign miss_valid_o = (state_q == S_MISS_REQ);
  assign miss_epn_o   = ea_q[EA_W-1:PAGE_BITS];
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_pa_o     = rsp_pa_q;
  assign rsp_exc_o    = rsp_exc_q;

`ifdef IMMU_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  // Saturating hit/miss event counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (hit_evt && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_evt && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;
`else
  logic unused_evt;
  assign unused_evt = hit_evt ^ miss_evt;
  assign hit_cnt_o  = '0;
  assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_immu_itlb.sv
// Scoreboard bench for immu_itlb: expected responses are queued when a lookup
// is issued and compared when rsp_valid is seen; a simple walker model answers
// refill requests. Counter expectations follow IMMU_PERF_CNT_EN.
module tb_immu_itlb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_ea;
  logic [7:0]  pid0, pid1, pid2;
  logic        msr_is, msr_pr;
  logic        rsp_valid;
  logic [31:0] rsp_pa;
  logic [4:0]  rsp_exc;
  logic        miss_valid, miss_ready;
  logic [19:0] miss_epn;
  logic        fill_valid, fill_err, fill_ts;
  logic [7:0]  fill_tid;
  logic [19:0] fill_epn, fill_rpn;
  logic [5:0]  fill_permis;
  logic        inv_all;
  logic [31:0] hit_cnt, miss_cnt;

  typedef struct packed {
    logic [31:0] pa;
    logic [4:0]  exc;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   last_rsp_cyc = 0;
  int   snap;

  immu_itlb dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_ea_i(req_ea),
    .pid0_i(pid0), .pid1_i(pid1), .pid2_i(pid2),
    .msr_is_i(msr_is), .msr_pr_i(msr_pr),
    .rsp_valid_o(rsp_valid), .rsp_pa_o(rsp_pa), .rsp_exc_o(rsp_exc),
    .miss_valid_o(miss_valid), .miss_ready_i(miss_ready), .miss_epn_o(miss_epn),
    .fill_valid_i(fill_valid), .fill_err_i(fill_err), .fill_ts_i(fill_ts),
    .fill_tid_i(fill_tid), .fill_epn_i(fill_epn), .fill_rpn_i(fill_rpn),
    .fill_permis_i(fill_permis), .inv_all_i(inv_all),
    .hit_cnt_o(hit_cnt), .miss_cnt_o(miss_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Response monitor: every rsp_valid pops one expectation.
  always @(negedge clk) begin
    if (rsp_valid) begin
      check("rsp_expected", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        sb_e = sb_q.pop_front();
        check("rsp_pa", rsp_pa, sb_e.pa);
        check("rsp_exc", rsp_exc, sb_e.exc);
      end
      rsp_cnt++;
      last_rsp_cyc = cyc;
    end
  end

  task automatic fill_entry(input logic ts, input logic [7:0] tid, input logic [19:0] epn,
                            input logic [19:0] rpn, input logic [5:0] perm, input logic inv);
    @(negedge clk);
    fill_valid = 1'b1; fill_err = 1'b0; fill_ts = ts; fill_tid = tid;
    fill_epn = epn; fill_rpn = rpn; fill_permis = perm; inv_all = inv;
    @(negedge clk);
    fill_valid = 1'b0; inv_all = 1'b0;
  endtask

  // Issue one lookup; on an expected miss, act as the walker (fill or fill_err).
  task automatic do_lookup(input logic [31:0] ea, input logic pr, input bit exp_miss,
                           input bit err, input logic [19:0] rpn,
                           input logic [31:0] exp_pa, input logic [4:0] exp_exc);
    int target, n, acc_cyc;
    exp_t e;
    e.pa = exp_pa; e.exc = exp_exc;
    sb_q.push_back(e);
    target = rsp_cnt + 1;
    @(negedge clk);
    check("req_ready", req_ready, 1);
    req_ea = ea; msr_pr = pr; req_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_miss) begin
      n = 0;
      while (!miss_valid && n < 20) begin @(negedge clk); n++; end
      check("miss_valid", miss_valid, 1);
      check("miss_epn", miss_epn, ea[31:12]);
      repeat (2) @(negedge clk);
      check("miss_hold", {miss_valid, miss_epn}, {1'b1, ea[31:12]});
      miss_ready = 1'b1;
      @(negedge clk);
      miss_ready = 1'b0;
      fill_valid = 1'b1; fill_err = err; fill_ts = 1'b0; fill_tid = 8'd0;
      fill_epn = ea[31:12]; fill_rpn = rpn; fill_permis = 6'b110000;
      acc_cyc = cyc;
      @(negedge clk);
      fill_valid = 1'b0; fill_err = 1'b0;
    end
    n = 0;
    while (rsp_cnt < target && n < 20) begin @(negedge clk); n++; end
    check("rsp_seen", rsp_cnt, target);
    check("rsp_lat", last_rsp_cyc - acc_cyc, (exp_miss && err) ? 1 : 2);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_ea = '0; pid0 = '0; pid1 = '0; pid2 = '0;
    msr_is = 1'b0; msr_pr = 1'b0; miss_ready = 1'b0; fill_valid = 1'b0; fill_err = 1'b0;
    fill_ts = 1'b0; fill_tid = '0; fill_epn = '0; fill_rpn = '0; fill_permis = '0; inv_all = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_pa", rsp_pa, 0);
    check("rst_rsp_exc", rsp_exc, 0);
    check("rst_miss_valid", miss_valid, 0);
    check("rst_cnts", {hit_cnt, miss_cnt}, 64'd0);

    // Basic hit with supervisor execute
    fill_entry(1'b0, 8'd0, 20'h12345, 20'hABCDE, 6'b010000, 1'b0);
    do_lookup(32'h1234_5678, 1'b0, 0, 0, '0, 32'hABCD_E678, 5'b00000);

    // Miss with refill and replay, then a walker error
    do_lookup(32'h5555_5000, 1'b0, 1, 0, 20'h00777, 32'h0077_7000, 5'b00000);
    do_lookup(32'h6666_6000, 1'b0, 1, 1, '0, 32'h0, 5'b00001);
    // The errored fill left nothing behind
    do_lookup(32'h6666_6000, 1'b0, 1, 1, '0, 32'h0, 5'b00001);
    // TS mismatch is a miss
    msr_is = 1'b1;
    do_lookup(32'h1234_5678, 1'b0, 1, 1, '0, 32'h0, 5'b00001);
    msr_is = 1'b0;

    // Permission fault and TID matching
    fill_entry(1'b0, 8'd0, 20'h77777, 20'h11111, 6'b010000, 1'b0);
    do_lookup(32'h7777_7ABC, 1'b1, 0, 0, '0, 32'h0, 5'b00010);
    do_lookup(32'h7777_7ABC, 1'b0, 0, 0, '0, 32'h1111_1ABC, 5'b00000);
    fill_entry(1'b0, 8'd5, 20'h88888, 20'h22222, 6'b110000, 1'b0);
    pid0 = 8'd1; pid1 = 8'd2; pid2 = 8'd3;
    do_lookup(32'h8888_8000, 1'b1, 1, 1, '0, 32'h0, 5'b00001);
    pid2 = 8'd5;
    do_lookup(32'h8888_8000, 1'b1, 0, 0, '0, 32'h2222_2000, 5'b00000);
    pid0 = 8'd0; pid1 = 8'd0; pid2 = 8'd0;

    // Replacement: fill all 8, then two more wrap onto entries 0 and 1
    @(negedge clk); inv_all = 1'b1;
    @(negedge clk); inv_all = 1'b0;
    for (int i = 0; i < 8; i++)
      fill_entry(1'b0, 8'd0, 20'h00100 + 20'(i), 20'h00200 + 20'(i), 6'b010000, 1'b0);
    fill_entry(1'b0, 8'd0, 20'h00300, 20'h00400, 6'b010000, 1'b0);
    fill_entry(1'b0, 8'd0, 20'h00301, 20'h00401, 6'b010000, 1'b0);
    do_lookup(32'h0010_0000, 1'b0, 1, 1, '0, 32'h0, 5'b00001);
    do_lookup(32'h0010_1000, 1'b0, 1, 1, '0, 32'h0, 5'b00001);
    do_lookup(32'h0010_2ABC, 1'b0, 0, 0, '0, 32'h0020_2ABC, 5'b00000);
    do_lookup(32'h0030_0000, 1'b0, 0, 0, '0, 32'h0040_0000, 5'b00000);
    do_lookup(32'h0030_1004, 1'b0, 0, 0, '0, 32'h0040_1004, 5'b00000);
    // inv_all with a fill in the same cycle keeps only the new entry
    fill_entry(1'b0, 8'd0, 20'h00500, 20'h00600, 6'b010000, 1'b1);
    do_lookup(32'h0050_0FFF, 1'b0, 0, 0, '0, 32'h0060_0FFF, 5'b00000);
    do_lookup(32'h0010_2000, 1'b0, 1, 1, '0, 32'h0, 5'b00001);

    // Multi-hit
    fill_entry(1'b0, 8'd0, 20'h00009, 20'h0000A, 6'b010000, 1'b1);
    fill_entry(1'b0, 8'd0, 20'h00009, 20'h0000B, 6'b010000, 1'b0);
    do_lookup(32'h0000_9000, 1'b0, 0, 0, '0, 32'h0, 5'b00100);

    // Reset while waiting for a fill: no response, array cleared
    @(negedge clk);
    req_ea = 32'hDEAD_0000; msr_pr = 1'b0; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    snap = 0;
    while (!miss_valid && snap < 20) begin @(negedge clk); snap++; end
    check("rst_case_miss", miss_valid, 1);
    miss_ready = 1'b1;
    @(negedge clk);
    miss_ready = 1'b0;
    snap = rsp_cnt;
    rst_n = 1'b0;
    #1;
    check("midrst_req_ready", req_ready, 1);
    check("midrst_miss_valid", miss_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("midrst_no_rsp", rsp_cnt, snap);
    check("midrst_cnts", {hit_cnt, miss_cnt}, 64'd0);

    // Formerly duplicated page now misses; fill, replay, then three hits
    do_lookup(32'h0000_9123, 1'b0, 1, 0, 20'h0000C, 32'h0000_C123, 5'b00000);
    for (int i = 0; i < 3; i++)
      do_lookup(32'h0000_9ABC, 1'b1, 0, 0, '0, 32'h0000_CABC, 5'b00000);
`ifdef IMMU_PERF_CNT_EN
    check("hit_cnt", hit_cnt, 32'd4);
    check("miss_cnt", miss_cnt, 32'd1);
`else
    check("hit_cnt", hit_cnt, 32'd0);
    check("miss_cnt", miss_cnt, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
